// File: rtl/module_tick_generator.sv
// Programmable tick generator: emits a one-cycle tick every period+1 clocks,
// either continuously or for a fixed burst, with done pulse and tick counter.
module module_tick_generator #(
   parameter int unsigned PRESCALER_WIDTH = 8,
   parameter int unsigned COUNT_WIDTH     = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic                       stop,
   input  logic [PRESCALER_WIDTH-1:0] period,
   input  logic [COUNT_WIDTH-1:0]     burst,
   output logic                       tick,
   output logic                       busy,
   output logic                       done,
   output logic [COUNT_WIDTH-1:0]     tick_count
);

   localparam int unsigned PW = PRESCALER_WIDTH;
   localparam int unsigned CW = COUNT_WIDTH;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [PW-1:0] per_q, per_d;
   logic [CW-1:0] burst_q, burst_d;
   logic [CW-1:0] count_d, count_inc;
   logic          tick_d, busy_d, done_d;

   // State and registered outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         pre_q      <= '0;
         per_q      <= '0;
         burst_q    <= '0;
         tick       <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         tick_count <= '0;
      end else begin
         state_q    <= state_d;
         pre_q      <= pre_d;
         per_q      <= per_d;
         burst_q    <= burst_d;
         tick       <= tick_d;
         busy       <= busy_d;
         done       <= done_d;
         tick_count <= count_d;
      end
   end

   // Next state and next output values; stop takes priority over a due tick
   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      per_d     = per_q;
      burst_d   = burst_q;
      tick_d    = 1'b0;
      busy_d    = busy;
      done_d    = 1'b0;
      count_d   = tick_count;
      count_inc = tick_count + CW'(1);

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (start && !stop) begin
               state_d = RUN;
               per_d   = period;
               burst_d = burst;
               pre_d   = '0;
               count_d = '0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
               pre_d   = '0;
               busy_d  = 1'b0;
            end else if (pre_q == per_q) begin
               pre_d   = '0;
               tick_d  = 1'b1;
               count_d = count_inc;
               if (burst_q != '0 && count_inc == burst_q) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end
            end else begin
               pre_d = pre_q + PW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = IDLE;
            pre_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule
